sr_flag_bank: RTL and testbench

Parametrised, clocked bank of `WIDTH` independent set/reset flag cells. It replaces the single level-sensitive SR latch in the register/control path. Each cell is a true edge-triggered flop with a selectable set/reset conflict policy, optional rising-edge set qualification, and sticky overflow detection for set events lost while the flag is already high. The block drives interrupt-style status flags and a lowest-index summary into CPU control logic.

---
 rtl/sr_pkg.sv | 33 +++
 rtl/sr_cell.sv | 65 ++++++
 rtl/sr_flag_bank.sv | 62 ++++++
 tb/tb_sr_flag_bank.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/sr_pkg.sv
// rtl/sr_pkg.sv - set/reset conflict policy codes and next-state resolver
// Contents:
//   SR_HOLD, SR_SET_DOM, SR_RST_DOM, SR_TOGGLE : conflict policy codes
//   sr_resolve(q, s, r, mode)                  : next flag state for one channel
package sr_pkg;

  localparam int SR_HOLD    = 0;
  localparam int SR_SET_DOM = 1;
  localparam int SR_RST_DOM = 2;
  localparam int SR_TOGGLE  = 3;

  // Any mode outside 0..3 falls through to hold.
  function automatic logic sr_resolve(input logic q, input logic s, input logic r,
                                      input int mode);
    logic nq;
    nq = q;
    case ({s, r})
      2'b10: nq = 1'b1;
      2'b01: nq = 1'b0;
      2'b11: begin
        case (mode)
          SR_SET_DOM: nq = 1'b1;
          SR_RST_DOM: nq = 1'b0;
          SR_TOGGLE:  nq = ~q;
          default:    nq = q;
        endcase
      end
      default: nq = q;
    endcase
    return nq;
  endfunction

endpackage

// File: rtl/sr_cell.sv
// rtl/sr_cell.sv - one edge-triggered set/reset flag channel
// Ports:
//   clk, reset     : clock, asynchronous active-high reset
//   en             : update enable
//   clr_all        : synchronous clear of q/ovf/rise (overrides en)
//   s, r           : set / reset request
//   q              : registered flag
//   rise           : registered 0->1 pulse of q
//   ovf            : sticky lost-set flag
module sr_cell
  import sr_pkg::*;
#(
  parameter int CONFLICT = SR_HOLD,
  parameter int EDGE_SET = 0
) (
  input  logic clk,
  input  logic reset,
  input  logic en,
  input  logic clr_all,
  input  logic s,
  input  logic r,
  output logic q,
  output logic rise,
  output logic ovf
);

  logic s_prev;
  logic s_eff;
  logic q_res;
  logic ovf_clr;
  logic ovf_set;

  assign s_eff = (EDGE_SET != 0) ? (s & ~s_prev) : s;
  assign q_res = sr_resolve(q, s_eff, r, CONFLICT);

  // R clears the overflow only when it actually drives the flag low:
  // plain reset, reset-dominant conflict, or a toggle from 1 to 0.
  assign ovf_clr = r & (~s_eff | (CONFLICT == SR_RST_DOM) |
                        ((CONFLICT == SR_TOGGLE) & ~q_res));
  assign ovf_set = s_eff & q & q_res;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      q      <= 1'b0;
      rise   <= 1'b0;
      ovf    <= 1'b0;
      s_prev <= 1'b0;
    end else begin
      // Edge history tracks S every cycle, so edges seen while disabled are lost.
      s_prev <= s;
      if (clr_all) begin
        q    <= 1'b0;
        rise <= 1'b0;
        ovf  <= 1'b0;
      end else if (!en) begin
        rise <= 1'b0;
      end else begin
        q    <= q_res;
        rise <= q_res & ~q;
        ovf  <= (ovf & ~ovf_clr) | ovf_set;
      end
    end
  end

endmodule

// File: rtl/sr_flag_bank.sv
// rtl/sr_flag_bank.sv - bank of WIDTH set/reset flags with summary outputs
// Ports:
//   clk, reset     : clock, asynchronous active-high reset
//   en             : global update enable
//   clr_all        : synchronous clear of all Q/ovf/rise
//   S, R           : per-channel set / reset requests
//   Q, Q_not       : registered flags and their complement
//   rise           : per-channel one-cycle rising pulse
//   ovf            : per-channel sticky lost-set flag
//   any_q          : OR of Q
//   first_idx      : lowest index with Q set, 0 when none
module sr_flag_bank
  import sr_pkg::*;
#(
  parameter int WIDTH    = 8,
  parameter int CONFLICT = 0,
  parameter int EDGE_SET = 0,
  parameter int IDX_W    = (WIDTH > 1) ? $clog2(WIDTH) : 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             clr_all,
  input  logic [WIDTH-1:0] S,
  input  logic [WIDTH-1:0] R,
  output logic [WIDTH-1:0] Q,
  output logic [WIDTH-1:0] Q_not,
  output logic [WIDTH-1:0] rise,
  output logic [WIDTH-1:0] ovf,
  output logic             any_q,
  output logic [IDX_W-1:0] first_idx
);

  for (genvar i = 0; i < WIDTH; i++) begin : g_cell
    sr_cell #(
      .CONFLICT(CONFLICT),
      .EDGE_SET(EDGE_SET)
    ) u_cell (
      .clk    (clk),
      .reset  (reset),
      .en     (en),
      .clr_all(clr_all),
      .s      (S[i]),
      .r      (R[i]),
      .q      (Q[i]),
      .rise   (rise[i]),
      .ovf    (ovf[i])
    );
  end

  assign Q_not = ~Q;
  assign any_q = |Q;

  // Scan from the top down so the lowest set index is the last write.
  always_comb begin
    first_idx = '0;
    for (int i = WIDTH - 1; i >= 0; i--) begin
      if (Q[i]) first_idx = IDX_W'(i);
    end
  end

endmodule

// File: tb/tb_sr_flag_bank.sv
// tb/tb_sr_flag_bank.sv - self-checking bench for sr_flag_bank
module tb_sr_flag_bank;

  localparam int N_DUT = 5;
  localparam int F_Q = 0, F_QN = 1, F_RISE = 2, F_OVF = 3, F_ANY = 4, F_IDX = 5;
  // instance select: 0 hold, 1 set-dom, 2 reset-dom, 3 toggle (all level S),
  // 4 reset-dom with edge-qualified S
  localparam int D_HOLD = 0, D_SDOM = 1, D_RDOM = 2, D_TOG = 3, D_EDGE = 4;

  logic       clk;
  logic       reset;
  logic       en;
  logic       clr_all;
  logic [7:0] S;
  logic [7:0] R;

  logic [7:0] q_o    [N_DUT];
  logic [7:0] qn_o   [N_DUT];
  logic [7:0] rise_o [N_DUT];
  logic [7:0] ovf_o  [N_DUT];
  logic       any_o  [N_DUT];
  logic [2:0] idx_o  [N_DUT];

  for (genvar g = 0; g < N_DUT; g++) begin : g_dut
    sr_flag_bank #(
      .WIDTH   (8),
      .CONFLICT((g == 4) ? 2 : g),
      .EDGE_SET((g == 4) ? 1 : 0)
    ) u_dut (
      .clk      (clk),
      .reset    (reset),
      .en       (en),
      .clr_all  (clr_all),
      .S        (S),
      .R        (R),
      .Q        (q_o[g]),
      .Q_not    (qn_o[g]),
      .rise     (rise_o[g]),
      .ovf      (ovf_o[g]),
      .any_q    (any_o[g]),
      .first_idx(idx_o[g])
    );
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string      name;
    int         sel;
    int         field;
    logic [7:0] mask;
    logic [7:0] val;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_pass   = 0;

  function automatic logic [7:0] observe(input int sel, input int field);
    case (field)
      F_Q:    return q_o[sel];
      F_QN:   return qn_o[sel];
      F_RISE: return rise_o[sel];
      F_OVF:  return ovf_o[sel];
      F_ANY:  return {7'd0, any_o[sel]};
      default: return {5'd0, idx_o[sel]};
    endcase
  endfunction

  task automatic push(input string name, input int sel, input int field,
                      input logic [7:0] mask, input logic [7:0] val);
    exp_t e;
    e.name = name; e.sel = sel; e.field = field; e.mask = mask; e.val = val;
    sb.push_back(e);
  endtask

  task automatic sb_compare();
    exp_t       e;
    logic [7:0] got;
    while (sb.size() > 0) begin
      e   = sb.pop_front();
      got = observe(e.sel, e.field) & e.mask;
      n_checks++;
      if (got !== e.val)
        $display("FAIL %s (dut%0d): got %h expected %h", e.name, e.sel, got, e.val);
      else
        n_pass++;
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    sb_compare();
  endtask

  task automatic test_reset();
    reset = 1'b1; en = 1'b1; clr_all = 1'b0;
    for (int i = 0; i < 3; i++) begin
      S = 8'($urandom); R = 8'($urandom);
      @(posedge clk);
      #1;
    end
    for (int d = 0; d < N_DUT; d++) begin
      push("rst_q",    d, F_Q,    8'hFF, 8'h00);
      push("rst_qn",   d, F_QN,   8'hFF, 8'hFF);
      push("rst_rise", d, F_RISE, 8'hFF, 8'h00);
      push("rst_ovf",  d, F_OVF,  8'hFF, 8'h00);
      push("rst_any",  d, F_ANY,  8'hFF, 8'h00);
      push("rst_idx",  d, F_IDX,  8'hFF, 8'h00);
    end
    sb_compare();
    reset = 1'b0; S = 8'h00; R = 8'h00;
    step();
    S = 8'h05;
    push("rel_q",    D_HOLD, F_Q,    8'hFF, 8'h05);
    push("rel_rise", D_HOLD, F_RISE, 8'hFF, 8'h05);
    push("rel_idx",  D_HOLD, F_IDX,  8'hFF, 8'h00);
    step();
    S = 8'h00;
    push("rel_q2",    D_HOLD, F_Q,    8'hFF, 8'h05);
    push("rel_rise2", D_HOLD, F_RISE, 8'hFF, 8'h00);
    step();
  endtask

  task automatic test_conflict();
    clr_all = 1'b1; S = 8'h00; R = 8'h00;
    step();
    clr_all = 1'b0; S = 8'h01;
    for (int d = 0; d < 4; d++) push("cf_init", d, F_Q, 8'hFF, 8'h01);
    step();
    S = 8'h03; R = 8'h03;
    push("cf_hold1", D_HOLD, F_Q,    8'hFF, 8'h01);
    push("cf_hovf1", D_HOLD, F_OVF,  8'hFF, 8'h01);
    push("cf_sdom1", D_SDOM, F_Q,    8'hFF, 8'h03);
    push("cf_sovf1", D_SDOM, F_OVF,  8'hFF, 8'h01);
    push("cf_rdom1", D_RDOM, F_Q,    8'hFF, 8'h00);
    push("cf_tog1",  D_TOG,  F_Q,    8'hFF, 8'h02);
    push("cf_trs1",  D_TOG,  F_RISE, 8'hFF, 8'h02);
    step();
    push("cf_hold2", D_HOLD, F_Q,    8'hFF, 8'h01);
    push("cf_sdom2", D_SDOM, F_Q,    8'hFF, 8'h03);
    push("cf_sovf2", D_SDOM, F_OVF,  8'hFF, 8'h03);
    push("cf_rdom2", D_RDOM, F_Q,    8'hFF, 8'h00);
    push("cf_tog2",  D_TOG,  F_Q,    8'hFF, 8'h01);
    push("cf_trs2",  D_TOG,  F_RISE, 8'hFF, 8'h01);
    push("cf_tovf2", D_TOG,  F_OVF,  8'hFF, 8'h00);
    step();
    S = 8'h00; R = 8'h00;
  endtask

  task automatic test_edge_set();
    logic [7:0] s_seq[4];
    logic [7:0] r_seq[4];
    logic [7:0] eq[4];
    logic [7:0] er[4];
    logic [7:0] lq[4];
    logic [7:0] lr[4];
    s_seq = '{8'h08, 8'h08, 8'h08, 8'h08};
    r_seq = '{8'h00, 8'h08, 8'h00, 8'h00};
    eq    = '{8'h08, 8'h00, 8'h00, 8'h00};
    er    = '{8'h08, 8'h00, 8'h00, 8'h00};
    lq    = '{8'h08, 8'h00, 8'h08, 8'h08};
    lr    = '{8'h08, 8'h00, 8'h08, 8'h00};
    clr_all = 1'b1; S = 8'h00; R = 8'h00;
    step();
    clr_all = 1'b0;
    for (int c = 0; c < 4; c++) begin
      S = s_seq[c]; R = r_seq[c];
      push($sformatf("edge_q%0d", c),  D_EDGE, F_Q,    8'h08, eq[c]);
      push($sformatf("edge_r%0d", c),  D_EDGE, F_RISE, 8'h08, er[c]);
      push($sformatf("level_q%0d", c), D_RDOM, F_Q,    8'h08, lq[c]);
      push($sformatf("level_r%0d", c), D_RDOM, F_RISE, 8'h08, lr[c]);
      step();
    end
    S = 8'h00; R = 8'h00;
  endtask

  task automatic test_overflow();
    clr_all = 1'b1;
    step();
    clr_all = 1'b0; S = 8'h80;
    push("ov_set_q",  D_HOLD, F_Q,   8'h80, 8'h80);
    push("ov_set_o",  D_HOLD, F_OVF, 8'h80, 8'h00);
    step();
    S = 8'h00;
    push("ov_idle_o", D_HOLD, F_OVF, 8'h80, 8'h00);
    step();
    S = 8'h80;
    push("ov_lost_o", D_HOLD, F_OVF, 8'h80, 8'h80);
    step();
    S = 8'h00; R = 8'h80;
    push("ov_rst_q",  D_HOLD, F_Q,   8'h80, 8'h00);
    push("ov_rst_o",  D_HOLD, F_OVF, 8'h80, 8'h00);
    step();
    R = 8'h00; en = 1'b0; S = 8'h80;
    push("ov_dis_q",  D_HOLD, F_Q,    8'h80, 8'h00);
    push("ov_dis_r",  D_HOLD, F_RISE, 8'h80, 8'h00);
    step();
    en = 1'b1; S = 8'h00;
    step();
  endtask

  task automatic test_clr_vs_en();
    S = 8'hFF;
    push("ce_set_q", D_HOLD, F_Q, 8'hFF, 8'hFF);
    step();
    push("ce_ovf", D_HOLD, F_OVF, 8'hFF, 8'hFF);
    step();
    en = 1'b0; clr_all = 1'b1;
    push("ce_clr_q",    D_HOLD, F_Q,    8'hFF, 8'h00);
    push("ce_clr_ovf",  D_HOLD, F_OVF,  8'hFF, 8'h00);
    push("ce_clr_rise", D_HOLD, F_RISE, 8'hFF, 8'h00);
    step();
    en = 1'b1; clr_all = 1'b0; S = 8'h00;
    step();
  endtask

  task automatic test_prio_enc();
    clr_all = 1'b1;
    step();
    clr_all = 1'b0; S = 8'h80;
    push("pe_idx7", D_HOLD, F_IDX, 8'hFF, 8'h07);
    push("pe_any7", D_HOLD, F_ANY, 8'hFF, 8'h01);
    step();
    S = 8'h04;
    push("pe_q84",  D_HOLD, F_Q,   8'hFF, 8'h84);
    push("pe_idx2", D_HOLD, F_IDX, 8'hFF, 8'h02);
    push("pe_any2", D_HOLD, F_ANY, 8'hFF, 8'h01);
    step();
    S = 8'h00;
    #2;
    reset = 1'b1;
    #1;
    push("pe_async_q",   D_HOLD, F_Q,   8'hFF, 8'h00);
    push("pe_async_qn",  D_HOLD, F_QN,  8'hFF, 8'hFF);
    push("pe_async_any", D_HOLD, F_ANY, 8'hFF, 8'h00);
    push("pe_async_idx", D_HOLD, F_IDX, 8'hFF, 8'h00);
    sb_compare();
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1; en = 1'b1; clr_all = 1'b0; S = 8'h00; R = 8'h00;
    #1;
    test_reset();
    test_conflict();
    test_edge_set();
    test_overflow();
    test_clr_vs_en();
    test_prio_enc();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
